reg_port_arb: RTL and testbench

REG_PORT_ARB -- requirements
Module: reg_port_arb

---
 rtl/reg_arb_pkg.sv | 15 +
 rtl/reg_arb_rr.sv | 31 +++
 rtl/reg_port_arb.sv | 202 ++++++++++++++++++++
 tb/tb_reg_port_arb.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_arb_pkg.sv
// reg_arb_pkg: shared types and defaults for the register-port arbiter.
package reg_arb_pkg;

    // Transaction phases: one access in flight at a time.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    // Default number of requesters sharing the register port.
    localparam int DEFAULT_N_REQ = 3;

endpackage

// File: rtl/reg_arb_rr.sv
// reg_arb_rr: combinational round-robin picker. Scans the request vector
// starting at ptr and returns a one-hot grant (all zero if nobody requests).
module reg_arb_rr
    import reg_arb_pkg::*;
#(
    parameter int N_REQ = DEFAULT_N_REQ,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] grant
);

    int   idx;
    logic found;

    // First active requester at or after ptr (wrapping) wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_port_arb.sv
// reg_port_arb: shares one register-bridge port among N_REQ requesters.
// Round-robin grant, one transaction in flight (IDLE -> ISSUE -> WAIT -> RESP).
// Optional ack watchdog enabled by defining REG_ARB_TIMEOUT_EN.
`ifndef AXI_WIDTH
`define AXI_WIDTH 32
`endif

module reg_port_arb
    import reg_arb_pkg::*;
#(
    parameter int N_REQ          = DEFAULT_N_REQ,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = `AXI_WIDTH,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [N_REQ-1:0]             req_valid,
    output logic [N_REQ-1:0]             req_ready,
    input  logic [N_REQ-1:0]             req_we,
    input  logic [N_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [N_REQ*DATA_WIDTH-1:0]  req_wdata,
    output logic [N_REQ-1:0]             rsp_valid,
    output logic [DATA_WIDTH-1:0]        rsp_rdata,
    output logic                         rsp_err,
    output logic                         reg_wr_en,
    output logic [ADDR_WIDTH-1:0]        reg_wr_addr,
    output logic [DATA_WIDTH-1:0]        reg_wr_data,
    input  logic                         reg_wr_ack,
    output logic                         reg_rd_en,
    output logic [ADDR_WIDTH-1:0]        reg_rd_addr,
    input  logic [DATA_WIDTH-1:0]        reg_rd_data,
    input  logic                         reg_rd_ack
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_t              state;
    arb_state_t              state_next;
    logic [PTR_W-1:0]        ptr;
    logic [PTR_W-1:0]        owner;
    logic [N_REQ-1:0]        grant;
    logic [PTR_W-1:0]        grant_idx;
    logic                    do_grant;
    logic                    txn_we;
    logic [ADDR_WIDTH-1:0]   txn_addr;
    logic [DATA_WIDTH-1:0]   txn_wdata;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    ack_hit;
    logic                    timed_out;

    reg_arb_rr #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant)
    );

    // A grant only happens in IDLE; the one-hot grant is encoded to an index.
    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                grant_idx = PTR_W'(i);
            end
        end
    end

    assign do_grant = (state == IDLE) && (|grant);

    // Only the ack matching the captured direction counts, and only while issued/waiting.
    assign ack_hit = ((state == ISSUE) || (state == WAIT)) &&
                     (txn_we ? reg_wr_ack : reg_rd_ack);

`ifdef REG_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;

    // Watchdog: cleared while issuing, counts WAIT cycles without an ack.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wait_cnt <= '0;
        end else if (state == ISSUE) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign timed_out = (state == WAIT) && !ack_hit &&
                       (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Error flag is updated as the response is formed and held afterwards.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_q <= 1'b0;
        end else if (ack_hit) begin
            err_q <= 1'b0;
        end else if (timed_out) begin
            err_q <= 1'b1;
        end
    end

    assign rsp_err = err_q;
`else
    assign timed_out = 1'b0;
    assign rsp_err   = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic for the single in-flight transaction.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (do_grant) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = ack_hit ? RESP : WAIT;
            end
            WAIT: begin
                if (ack_hit || timed_out) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Capture the winning request and advance the round-robin pointer past it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr       <= '0;
            owner     <= '0;
            txn_we    <= 1'b0;
            txn_addr  <= '0;
            txn_wdata <= '0;
        end else if (do_grant) begin
            owner     <= grant_idx;
            txn_we    <= req_we[grant_idx];
            txn_addr  <= req_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            txn_wdata <= req_wdata[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
            if (grant_idx == PTR_W'(N_REQ - 1)) begin
                ptr <= '0;
            end else begin
                ptr <= grant_idx + 1'b1;
            end
        end
    end

    // Response data: read data on a read ack, zero for writes or timeouts, held otherwise.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata_q <= '0;
        end else if (ack_hit) begin
            rdata_q <= txn_we ? '0 : reg_rd_data;
        end else if (timed_out) begin
            rdata_q <= '0;
        end
    end

    // Output decode: ready only in IDLE out of reset, completion pulse to the owner in RESP.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        if (rstn && (state == IDLE)) begin
            req_ready = grant;
        end
        for (int i = 0; i < N_REQ; i++) begin
            if ((state == RESP) && (owner == PTR_W'(i))) begin
                rsp_valid[i] = 1'b1;
            end
        end
    end

    assign reg_wr_en   = (state == ISSUE) && txn_we;
    assign reg_rd_en   = (state == ISSUE) && !txn_we;
    assign reg_wr_addr = txn_addr;
    assign reg_rd_addr = txn_addr;
    assign reg_wr_data = txn_wdata;
    assign rsp_rdata   = rdata_q;

endmodule

// File: tb/tb_reg_port_arb.sv
// tb_reg_port_arb: scoreboard bench for reg_port_arb with a modelled register bridge.
// Timeout scenario is built in when REG_ARB_TIMEOUT_EN is defined.
`timescale 1ns/1ps

module tb_reg_port_arb;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rstn;
    logic [N-1:0]    req_valid, req_ready, req_we, rsp_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;
    logic            reg_wr_en, reg_rd_en, reg_wr_ack, reg_rd_ack;
    logic [AW-1:0]   reg_wr_addr, reg_rd_addr;
    logic [DW-1:0]   reg_wr_data, reg_rd_data;

    typedef struct {
        int          idx;
        logic        we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        logic        err;
        int          accept_cycle;
    } exp_t;

    exp_t sb[$];
    int   grant_log[$];
    exp_t mon_e;

    int tests_run  = 0;
    int failures   = 0;
    int cycle      = 0;
    int en_cycles  = 0;
    int rsp_count  = 0;
    int ack_delay  = 0;
    int cur_delay  = 0;
    int stray_req  = 0;
    int rand_max   = 20;
    bit rand_delay = 1'b0;
    bit no_ack     = 1'b0;
    bit expect_timeout = 1'b0;

    reg_port_arb #(
        .N_REQ          (N),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .reg_wr_en   (reg_wr_en),
        .reg_wr_addr (reg_wr_addr),
        .reg_wr_data (reg_wr_data),
        .reg_wr_ack  (reg_wr_ack),
        .reg_rd_en   (reg_rd_en),
        .reg_rd_addr (reg_rd_addr),
        .reg_rd_data (reg_rd_data),
        .reg_rd_ack  (reg_rd_ack)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Register contents as seen by the bridge model.
    function automatic logic [DW-1:0] rd_model(input logic [AW-1:0] a);
        if (a == 32'h10) return 32'hA5A5_A5A5;
        return a ^ 32'h5A5A_C3C3;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Raise one request, wait (bounded) for its accept, then drop it.
    task automatic applyStimulus(input int i, input logic we, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wdata);
        bit seen = 1'b0;
        req_we[i]              = we;
        req_addr[i*AW +: AW]   = addr;
        req_wdata[i*DW +: DW]  = wdata;
        req_valid[i]           = 1'b1;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            if (req_ready[i]) seen = 1'b1;
        end
        checkOutput($sformatf("accept_req%0d", i), seen, 1'b1);
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic waitDrain();
        bit done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            if (sb.size() == 0) done = 1'b1;
        end
        checkOutput("drain", done, 1'b1);
        @(posedge clk); #1;
    endtask

    // Bridge model: acks each issued access after a delay; also injects stray acks on request.
    initial begin : bridge
        int d;
        bit is_rd;
        int stray_done = 0;
        reg_wr_ack  = 1'b0;
        reg_rd_ack  = 1'b0;
        reg_rd_data = '0;
        forever begin
            @(posedge clk); #2;
            if (reg_rd_en || reg_wr_en) begin
                is_rd = reg_rd_en;
                if (sb.size() != 0) begin
                    checkOutput("bridge_dir", is_rd, !sb[0].we);
                    checkOutput("bridge_addr", is_rd ? reg_rd_addr : reg_wr_addr, sb[0].addr);
                    if (!is_rd) checkOutput("bridge_wdata", reg_wr_data, sb[0].wdata);
                end
                if (!no_ack) begin
                    d = rand_delay ? $urandom_range(0, rand_max) : ack_delay;
                    cur_delay = d;
                    repeat (d) begin @(posedge clk); #2; end
                    if (is_rd) begin
                        reg_rd_data = rd_model(reg_rd_addr);
                        reg_rd_ack  = 1'b1;
                    end else begin
                        reg_wr_ack  = 1'b1;
                    end
                    @(posedge clk); #2;
                    reg_rd_ack  = 1'b0;
                    reg_wr_ack  = 1'b0;
                    reg_rd_data = 32'hDEAD_DEAD;
                end
            end else if (stray_req != stray_done) begin
                stray_done++;
                reg_rd_data = 32'hBAD0_BAD0;
                reg_rd_ack  = 1'b1;
                reg_wr_ack  = 1'b1;
                @(posedge clk); #2;
                reg_rd_ack  = 1'b0;
                reg_wr_ack  = 1'b0;
            end
        end
    end

    // Monitor: pushes expectations on accept, pops and compares on completion.
    always @(negedge clk) begin
        if (reg_wr_en || reg_rd_en) en_cycles++;
        if (rstn) begin
            if (|req_ready) begin
                checkOutput("ready_onehot", $onehot(req_ready), 1'b1);
                checkOutput("ready_no_valid", req_ready & ~req_valid, '0);
                for (int i = 0; i < N; i++) begin
                    if (req_ready[i]) begin
                        mon_e.idx          = i;
                        mon_e.we           = req_we[i];
                        mon_e.addr         = req_addr[i*AW +: AW];
                        mon_e.wdata        = req_wdata[i*DW +: DW];
                        mon_e.rdata        = req_we[i] ? '0 : rd_model(req_addr[i*AW +: AW]);
                        mon_e.err          = 1'b0;
                        if (expect_timeout) begin
                            mon_e.rdata = '0;
                            mon_e.err   = 1'b1;
                        end
                        mon_e.accept_cycle = cycle;
                        sb.push_back(mon_e);
                        grant_log.push_back(i);
                    end
                end
            end
            if (|rsp_valid) begin
                rsp_count++;
                if (sb.size() == 0) begin
                    checkOutput("spurious_rsp", rsp_valid, '0);
                end else begin
                    mon_e = sb.pop_front();
                    checkOutput("rsp_owner", rsp_valid, 64'(1) << mon_e.idx);
                    checkOutput("rsp_rdata", rsp_rdata, mon_e.rdata);
                    checkOutput("rsp_err", rsp_err, mon_e.err);
                    if (mon_e.err)
                        checkOutput("timeout_latency", cycle - mon_e.accept_cycle, TO + 2);
                    else
                        checkOutput("rsp_latency", cycle - mon_e.accept_cycle, 2 + cur_delay);
                end
            end
        end
    end

    initial begin : main
        int en0;
        int rsp0;
        int issued;
        logic [N-1:0] taken;
        bit done;

        rstn      = 1'b0;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;

        // Reset state, with a read already pending on requester 0.
        req_we[0]          = 1'b0;
        req_addr[0 +: AW]  = 32'h10;
        req_valid          = 3'b001;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_req_ready", req_ready, '0);
        checkOutput("rst_rsp_valid", rsp_valid, '0);
        checkOutput("rst_en", {reg_wr_en, reg_rd_en}, '0);
        checkOutput("rst_addr", {reg_wr_addr, reg_rd_addr}, '0);
        checkOutput("rst_wdata", reg_wr_data, '0);
        checkOutput("rst_rsp", {rsp_rdata, rsp_err}, '0);

        // Single read, grant in the first cycle out of reset, ack one cycle after ISSUE.
        ack_delay = 1;
        en0 = en_cycles;
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        checkOutput("first_grant", req_ready, 3'b001);
        @(posedge clk); #1;
        req_valid = '0;
        waitDrain();
        checkOutput("read_en_pulses", en_cycles - en0, 1);

        // Write acked in its ISSUE cycle.
        ack_delay = 0;
        en0 = en_cycles;
        applyStimulus(2, 1'b1, 32'h24, 32'h1234_5678);
        waitDrain();
        checkOutput("write_en_pulses", en_cycles - en0, 1);

        // Contention: all three held for six transactions.
        grant_log.delete();
        en0  = en_cycles;
        rsp0 = rsp_count;
        for (int i = 0; i < N; i++) begin
            req_we[i]             = i[0];
            req_addr[i*AW +: AW]  = 32'h100 + 32'(i * 4);
            req_wdata[i*DW +: DW] = 32'hC0DE_0000 + 32'(i);
        end
        ack_delay = 1;
        req_valid = 3'b111;
        done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (grant_log.size() >= 6) done = 1'b1;
        end
        @(posedge clk); #1;
        req_valid = '0;
        waitDrain();
        checkOutput("contention_grants", grant_log.size(), 6);
        for (int k = 0; k < 6 && k < grant_log.size(); k++)
            checkOutput($sformatf("grant_order%0d", k), grant_log[k], k % 3);
        checkOutput("contention_en_pulses", en_cycles - en0, 6);
        checkOutput("contention_rsps", rsp_count - rsp0, 6);

        // Reset while waiting on an ack, then a stray ack after release.
        no_ack = 1'b1;
        rsp0 = rsp_count;
        applyStimulus(1, 1'b0, 32'h40, '0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b0;
        sb.delete();
        @(negedge clk);
        checkOutput("midrst_en", {reg_wr_en, reg_rd_en}, '0);
        checkOutput("midrst_rsp_valid", rsp_valid, '0);
        @(posedge clk); #1;
        rstn   = 1'b1;
        no_ack = 1'b0;
        stray_req++;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checkOutput("postrst_no_rsp", rsp_count - rsp0, 0);
        checkOutput("postrst_outputs", {rsp_valid, rsp_err, reg_wr_en, reg_rd_en}, '0);
        checkOutput("postrst_addr", reg_rd_addr, '0);
        checkOutput("postrst_rdata", rsp_rdata, '0);
        @(posedge clk); #1;
        req_valid = 3'b111;
        @(negedge clk);
        checkOutput("postrst_grant", req_ready, 3'b001);
        @(posedge clk); #1;
        req_valid = '0;
        waitDrain();

`ifdef REG_ARB_TIMEOUT_EN
        // No ack: watchdog answers with an error, and the next access is normal.
        no_ack = 1'b1;
        expect_timeout = 1'b1;
        applyStimulus(0, 1'b0, 32'h10, '0);
        @(posedge clk); #1;
        expect_timeout = 1'b0;
        waitDrain();
        no_ack = 1'b0;
        applyStimulus(1, 1'b0, 32'h10, '0);
        waitDrain();
        rand_max = 6;
`endif

        // Stray ack in IDLE, then randomized traffic and ack delays.
        stray_req++;
        repeat (3) @(posedge clk);
        #1;
        rand_delay = 1'b1;
        rsp0   = rsp_count;
        issued = 0;
        for (int c = 0; c < 4000 && (issued < 15 || req_valid != '0 || sb.size() != 0); c++) begin
            @(negedge clk);
            taken = req_ready;
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (taken[i]) begin
                    req_valid[i] = 1'b0;
                end else if (!req_valid[i] && issued < 15 && $urandom_range(0, 2) == 0) begin
                    req_we[i]             = 1'($urandom_range(0, 1));
                    req_addr[i*AW +: AW]  = $urandom;
                    req_wdata[i*DW +: DW] = $urandom;
                    req_valid[i]          = 1'b1;
                    issued++;
                end
            end
        end
        rand_delay = 1'b0;
        checkOutput("rand_all_answered", rsp_count - rsp0, 15);
        checkOutput("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
